// File: rtl/reduce_pkg.sv
// reduce_pkg: shared types and helpers for the reduce_ctrl reduction-engine controller.
//   op_t    : 3-bit reduction op code. Bit 2 inverts the final result. Bits [1:0] pick
//             the reduction class (00 AND, 01 OR, 10 XOR). 011 and 111 are reserved.
//   state_t : controller FSM states.
//   identity: accumulator start value for an op (1 for AND-class, 0 otherwise).
package reduce_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_RSV3 = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Reduction class selected by op[1:0]; 11 falls into the XOR class.
    localparam logic [1:0] CLS_AND = 2'b00;
    localparam logic [1:0] CLS_OR  = 2'b01;
    localparam logic [1:0] CLS_RSV = 2'b11;

    function automatic logic identity(input op_t op);
        return (op[1:0] == CLS_AND);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   Parameter N   : number of requesters.
//   req       in  : N-bit request vector.
//   ptr       in  : index of the highest-priority requester this round.
//   grant     out : one-hot grant (all zero when no request is pending).
//   grant_idx out : binary index of the granted requester (0 when no grant).
// Search order is ptr, ptr+1, ... wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int   j;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reduce_ctrl.sv
// reduce_ctrl: shared reduction-engine controller.
// Arbitrates NREQ requesters round-robin onto one sliced reduction datapath. The
// granted DW-bit operand is reduced SLICE bits per cycle and the one-bit result is
// returned with the owner's ID on a valid/ready response channel.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   [NREQ]      per-requester request valid
//   req_ready  out  [NREQ]      one-hot accept, only asserted in IDLE
//   req_op     in   [3*NREQ]    op code, requester i at [3i+2:3i]
//   req_data   in   [DW*NREQ]   operand, requester i at [DW*i+DW-1:DW*i]
//   rsp_valid  out              result valid (DONE)
//   rsp_ready  in               result accepted
//   rsp_id     out  [clog2 NREQ] owner of the result
//   rsp_bit    out              reduction result
//   rsp_err    out              illegal op flag
//   busy       out              high in RUN or DONE
//
// Build option REDUCE_CTRL_ERR_EN: when defined, ops 011/111 are flagged with
// rsp_err=1 and rsp_bit forced 0. When undefined, rsp_err stays 0 and op[1:0]=11
// reduces as XOR.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | arbiter active, waiting for a valid request to accept
// RUN   | consuming SLICE operand bits per cycle into the accumulator
// DONE  | result presented on rsp_*; held until rsp_ready
module reduce_ctrl
    import reduce_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int SLICE = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [OPW*NREQ-1:0]         req_op,
    input  logic [DW*NREQ-1:0]          req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic                        rsp_bit,
    output logic                        rsp_err,
    output logic                        busy
);

    localparam int NS = DW / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    op_t             op_q, op_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;
    logic            rsp_bit_q, rsp_bit_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            accept;
    op_t             op_sel;
    logic [DW-1:0]   data_sel;
    logic [SLICE-1:0] slice_bits;
    logic            acc_next;
    logic            last_slice;
    logic            illegal_op;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is already qualified by req_valid, so any ready bit means a handshake.
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = |req_ready;

    assign op_sel   = op_t'(req_op[OPW*int'(grant_idx) +: OPW]);
    assign data_sel = req_data[DW*int'(grant_idx) +: DW];

    assign slice_bits = shreg_q[SLICE-1:0];
    assign last_slice = (cnt_q == CW'(NS - 1));

    always_comb begin
        acc_next = acc_q;
        case (op_q[1:0])
            CLS_AND: acc_next = acc_q & (&slice_bits);
            CLS_OR:  acc_next = acc_q | (|slice_bits);
            default: acc_next = acc_q ^ (^slice_bits);
        endcase
    end

`ifdef REDUCE_CTRL_ERR_EN
    assign illegal_op = (op_q[1:0] == CLS_RSV);
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        op_d        = op_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_bit_d   = rsp_bit_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = data_sel;
                    op_d    = op_sel;
                    id_d    = grant_idx;
                    acc_d   = identity(op_sel);
                    cnt_d   = '0;
                    ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                shreg_d = shreg_q >> SLICE;
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    // Result uses the accumulator including this final slice.
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = illegal_op;
                    rsp_bit_d   = illegal_op ? 1'b0 : (acc_next ^ op_q[2]);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            op_q        <= OP_AND;
            id_q        <= '0;
            ptr_q       <= '0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_bit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            op_q        <= op_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_bit   = rsp_bit_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reduce_ctrl.sv
// tb_reduce_ctrl: directed plus randomized checks of reduce_ctrl (NREQ=4, DW=32,
// SLICE=8) against a whole-operand reduction model built on $countones.
module tb_reduce_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int NS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [DW*NREQ-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_bit;
    logic              rsp_err;
    logic              busy;

    int n_cmp = 0;
    int n_mis = 0;

    reduce_ctrl #(.NREQ(NREQ), .DW(DW), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bit   (rsp_bit),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Whole-operand reference: AND = all ones, OR = any one, XOR = odd popcount.
    function automatic logic model_bit(input logic [2:0] op, input logic [31:0] d);
        int   ones;
        logic r;
        ones = $countones(d);
        case (op[1:0])
            2'b00:   r = (ones == 32);
            2'b01:   r = (ones != 0);
            default: r = (ones % 2) == 1;
        endcase
`ifdef REDUCE_CTRL_ERR_EN
        if (op[1:0] == 2'b11) return 1'b0;
`endif
        return r ^ op[2];
    endfunction

    function automatic logic model_err(input logic [2:0] op);
`ifdef REDUCE_CTRL_ERR_EN
        return op[1:0] == 2'b11;
`else
        return (op == 3'b000) && (op != 3'b000);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] d);
        req_op[3*id +: 3]    = op;
        req_data[32*id +: 32] = d;
        req_valid[id]        = 1'b1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input int id, input logic [2:0] op, input logic [31:0] d);
        int lat;
        set_req(id, op, d);
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(1 << id));
        tick();
        req_valid[id] = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(NS));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_bit", 32'(rsp_bit), 32'(model_bit(op, d)));
        chk("rsp_err", 32'(rsp_err), 32'(model_err(op)));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
        chk("busy_clr", 32'(busy), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [1:0]  h_id;
        logic        h_bit;
        logic [31:0] d;
        logic [2:0]  op;
        int          id;
        int          rr_ids[$];
        int          rr_cyc[$];
        logic        rr_bits[$];
        logic [31:0] rr_data [NREQ];
        logic [2:0]  rr_op [NREQ];

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_bit", 32'(rsp_bit), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Directed op/operand cases.
        run_one(0, 3'b000, 32'hFFFF_FFFF);
        run_one(0, 3'b000, 32'hFFFF_FFFE);
        run_one(2, 3'b010, 32'h0000_0007);
        run_one(2, 3'b110, 32'h0000_0007);
        run_one(1, 3'b100, 32'hFFFF_FFFF);
        run_one(3, 3'b101, 32'h0000_0000);
        run_one(3, 3'b011, 32'h0000_0003);
        run_one(1, 3'b111, 32'h8000_0001);
        run_one(0, 3'b001, 32'h0100_0000);

        // Result held in DONE while rsp_ready stays low; no grants meanwhile.
        set_req(1, 3'b001, 32'h0010_0000);
        #1;
        chk("hold_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 3'b000, 32'h1234_5678);
        set_req(2, 3'b010, 32'h0000_0001);
        set_req(3, 3'b001, 32'h0000_0000);
        #1;
        chk("run_no_ready", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        chk("hold_latency", 32'(lat), 32'(NS));
        h_id  = 2'd1;
        h_bit = model_bit(3'b001, 32'h0010_0000);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'(h_id));
            chk("hold_bit", 32'(rsp_bit), 32'(h_bit));
            chk("hold_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hold_next_grant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        tick();

        // Reset during RUN discards the job and returns the pointer to 0.
        set_req(2, 3'b010, 32'h0000_0005);
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("midrst_ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        // Randomized single requests.
        for (int k = 0; k < 24; k++) begin
            id = $urandom_range(0, NREQ - 1);
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h0;
                2:       d = 32'hFFFF_FFFF ^ (32'h1 << $urandom_range(0, 31));
                default: d = $urandom;
            endcase
            run_one(id, op, d);
        end

        // All requesters pending from reset: strict rotation, one result per NS+2.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rr_op[i]   = 3'($urandom_range(0, 6));
            rr_data[i] = $urandom;
            set_req(i, rr_op[i], rr_data[i]);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                rr_ids.push_back(int'(rsp_id));
                rr_cyc.push_back(c);
                rr_bits.push_back(rsp_bit);
            end
        end
        chk("rr_count_ge5", 32'(rr_ids.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < rr_ids.size(); k++) begin
            chk("rr_id", 32'(rr_ids[k]), 32'(k % NREQ));
            chk("rr_bit", 32'(rr_bits[k]), 32'(model_bit(rr_op[k % NREQ], rr_data[k % NREQ])));
            if (k > 0) chk("rr_spacing", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'(NS + 2));
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
